mem_port_arbiter: RTL and testbench

- Shares the single-ported data memory between the instruction-fetch port (I) and the load/store port (D) of the pipelined RV32I core.
- Registered-grant, round-robin arbiter with a 3-state FSM. Each request takes exactly one memory access slot.
- Captures the memory's combinational read data and returns it with a one-cycle ack pulse.
- The requester stalls until it sees ack.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_port_arbiter_rr_arb2.sv | 35 +++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for mem_port_arbiter: FSM states, port select,
// and the memory read_part / write_part codes used by the load/store port.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      SEL_I = 1'b0,
      SEL_D = 1'b1
   } sel_t;

   // Read part codes (load width / extension)
   localparam logic [2:0] RP_W  = 3'd0;
   localparam logic [2:0] RP_HS = 3'd1;
   localparam logic [2:0] RP_HU = 3'd2;
   localparam logic [2:0] RP_BS = 3'd3;
   localparam logic [2:0] RP_BU = 3'd4;

   // Write part codes (store width)
   localparam logic [1:0] WP_W  = 2'd0;
   localparam logic [1:0] WP_H  = 2'd1;
   localparam logic [1:0] WP_B  = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-request picker (fetch vs load/store) with a last-grant register.
// Default: round-robin on a tie, the port not granted last wins.
// With MEM_ARB_DPRIO_EN defined: fixed priority, load/store always wins a tie.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_fetch_req,
   input  logic i_ls_req,
   input  logic i_accept,
   output logic o_pick_ls
);

   sel_t r_last_sel;

`ifdef MEM_ARB_DPRIO_EN
   // Fixed priority: load/store wins whenever it requests.
   assign o_pick_ls = i_ls_req;
`else
   // Round-robin: on a tie, grant load/store only if fetch won last time.
   assign o_pick_ls = i_ls_req & (~i_fetch_req | (r_last_sel == SEL_I));
`endif

   // Remember which port took the last grant.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         r_last_sel <= SEL_I;
      end else if (i_accept) begin
         r_last_sel <= o_pick_ls ? SEL_D : SEL_I;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported data memory between the fetch
// port (I) and the load/store port (D). Registered grant, one access slot per
// request, IDLE -> ACCESS -> RESP, ack pulses two cycles after the request is
// first seen. Tie policy comes from rr_arb2; define MEM_ARB_DPRIO_EN for fixed
// load/store priority instead of round-robin.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   // fetch port
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   // load/store port
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_read_part,
   input  logic [1:0]        d_write_part,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   // memory
   output logic              mem_read,
   output logic              mem_write,
   output logic [2:0]        mem_read_part,
   output logic [1:0]        mem_write_part,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

   state_t            r_state;
   sel_t              r_grant_sel;
   logic              r_d_rej;
   logic              r_i_ack;
   logic              r_d_ack;
   logic              r_d_err;
   logic [DATA_W-1:0] r_i_rdata;
   logic [DATA_W-1:0] r_d_rdata;

   logic              w_grant_now;
   logic              w_pick_d;
   logic              w_d_rej;
   logic              w_mem_write;

   assign w_grant_now = (r_state == IDLE) & (i_req | d_req);

   rr_arb2 u_arb (
      .clk        (clk),
      .rst        (rst),
      .i_fetch_req(i_req),
      .i_ls_req   (d_req),
      .i_accept   (w_grant_now),
      .o_pick_ls  (w_pick_d)
   );

   // Legality of the pending load/store: unknown part codes and misaligned
   // halfword/word accesses are rejected.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_d_rej = 1'b0;
      if (d_we) begin
         case (d_write_part)
            WP_W:    w_d_rej = (d_addr[1:0] != 2'b00);
            WP_H:    w_d_rej = d_addr[0];
            WP_B:    w_d_rej = 1'b0;
            default: w_d_rej = 1'b1;
         endcase
      end else begin
         case (d_read_part)
            RP_W:         w_d_rej = (d_addr[1:0] != 2'b00);
            RP_HS, RP_HU: w_d_rej = d_addr[0];
            RP_BS, RP_BU: w_d_rej = 1'b0;
            default:      w_d_rej = 1'b1;
         endcase
      end
   end

   // Arbitration FSM with registered grant, rdata capture and ack pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_grant_sel <= SEL_I;
         r_d_rej     <= 1'b0;
         r_i_ack     <= 1'b0;
         r_d_ack     <= 1'b0;
         r_d_err     <= 1'b0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
      end else begin
         r_i_ack <= 1'b0;
         r_d_ack <= 1'b0;
         r_d_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_now) begin
                  r_grant_sel <= w_pick_d ? SEL_D : SEL_I;
                  r_d_rej     <= w_pick_d & w_d_rej;
                  r_state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (r_grant_sel == SEL_I) begin
                  r_i_rdata <= mem_rdata;
                  r_i_ack   <= 1'b1;
               end else begin
                  r_d_rdata <= (d_we | r_d_rej) ? '0 : mem_rdata;
                  r_d_ack   <= 1'b1;
                  r_d_err   <= r_d_rej;
               end
               r_state <= RESP;
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Memory drive: quiet outside ACCESS, granted port's live inputs inside.
   always_comb begin
      mem_read       = 1'b0;
      w_mem_write    = 1'b0;
      mem_read_part  = RP_W;
      mem_write_part = WP_W;
      mem_addr       = '0;
      mem_wdata      = '0;
      if (r_state == ACCESS) begin
         if (r_grant_sel == SEL_I) begin
            mem_read = 1'b1;
            mem_addr = i_addr & WORD_MASK;
         end else begin
            mem_read       = ~d_we & ~r_d_rej;
            w_mem_write    = d_we & ~r_d_rej;
            mem_read_part  = d_read_part;
            mem_write_part = d_write_part;
            mem_addr       = d_addr;
            mem_wdata      = d_wdata;
         end
      end
   end

   // A store caught by reset must not reach memory in the reset cycle itself.
   assign mem_write = w_mem_write & ~rst;

   assign i_ack   = r_i_ack;
   assign i_rdata = r_i_rdata;
   assign d_ack   = r_d_ack;
   assign d_rdata = r_d_rdata;
   assign d_err   = r_d_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-addressed memory environment, behavioural
// reference (shadow memory, grant-order rule, fixed latencies), directed cases
// followed by randomized request rounds.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_req, i_ack;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              d_req, d_we, d_ack, d_err;
   logic [2:0]        d_read_part;
   logic [1:0]        d_write_part;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata, d_rdata;
   logic              mem_read, mem_write;
   logic [2:0]        mem_read_part;
   logic [1:0]        mem_write_part;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_read_part(d_read_part), .d_write_part(d_write_part),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_read_part(mem_read_part),
      .mem_write_part(mem_write_part), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // ---------------- memory environment (little-endian bytes) ----------------
   logic [7:0] env_mem [256];
   logic [7:0] a0, a1, a2, a3;
   logic       pre_en;
   logic [7:0] pre_a, pre_d;
   int         rd_cnt = 0, wr_cnt = 0;

   assign a0 = mem_addr;
   assign a1 = mem_addr + 8'd1;
   assign a2 = mem_addr + 8'd2;
   assign a3 = mem_addr + 8'd3;

   always_comb begin
      mem_rdata = '0;
      case (mem_read_part)
         RP_W:  mem_rdata = {env_mem[a3], env_mem[a2], env_mem[a1], env_mem[a0]};
         RP_HS: mem_rdata = {{16{env_mem[a1][7]}}, env_mem[a1], env_mem[a0]};
         RP_HU: mem_rdata = {16'h0, env_mem[a1], env_mem[a0]};
         RP_BS: mem_rdata = {{24{env_mem[a0][7]}}, env_mem[a0]};
         RP_BU: mem_rdata = {24'h0, env_mem[a0]};
         default: mem_rdata = '0;
      endcase
   end

   always @(posedge clk) begin
      if (pre_en) begin
         env_mem[pre_a] <= pre_d;
      end else if (mem_write) begin
         env_mem[a0] <= mem_wdata[7:0];
         if (mem_write_part != WP_B) env_mem[a1] <= mem_wdata[15:8];
         if (mem_write_part == WP_W) begin
            env_mem[a2] <= mem_wdata[23:16];
            env_mem[a3] <= mem_wdata[31:24];
         end
      end
      if (mem_read)  rd_cnt <= rd_cnt + 1;
      if (mem_write) wr_cnt <= wr_cnt + 1;
   end

   // ---------------- reference model ----------------
   logic [7:0]  ref_mem [256];
   bit          last_i = 1'b1;      // last granted port was fetch
   logic [31:0] exp_i_hold = '0;
   logic [31:0] exp_d_hold = '0;

   function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [2:0] rp);
      logic [7:0] b0, b1, b2, b3;
      b0 = ref_mem[a];
      b1 = ref_mem[a + 8'd1];
      b2 = ref_mem[a + 8'd2];
      b3 = ref_mem[a + 8'd3];
      case (rp)
         3'd0:    return {b3, b2, b1, b0};
         3'd1:    return 32'($signed({b1, b0}));
         3'd2:    return {16'h0, b1, b0};
         3'd3:    return 32'($signed(b0));
         default: return {24'h0, b0};
      endcase
   endfunction

   task automatic ref_store(input logic [7:0] a, input logic [1:0] wp, input logic [31:0] v);
      int nbytes;
      nbytes = (wp == 2'd0) ? 4 : (wp == 2'd1) ? 2 : 1;
      for (int k = 0; k < nbytes; k++) ref_mem[a + 8'(k)] = v[8*k +: 8];
   endtask

   function automatic bit ref_reject(input logic we, input logic [2:0] rp,
                                     input logic [1:0] wp, input logic [7:0] a);
      if (we) return (wp == 2'd3) || (wp == 2'd1 && a[0]) || (wp == 2'd0 && a[1:0] != 2'b00);
      return (rp > 3'd4) || ((rp == 3'd1 || rp == 3'd2) && a[0]) || (rp == 3'd0 && a[1:0] != 2'b00);
   endfunction

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One round: present fetch and/or load/store at once, expect each served in
   // model grant order, ack latency 2 for the first and 5 for the second.
   task automatic do_round(input bit wi, input bit wd, input logic [7:0] ia,
                           input logic dwe, input logic [2:0] rp, input logic [1:0] wp,
                           input logic [7:0] da, input logic [31:0] wdat);
      bit rej, d_first, pend_i, pend_d, take_d;
      logic [31:0] exp_i, exp_d;
      int lat_i, lat_d, n_rd, n_wr, rd0, wr0;
      rej   = wd && ref_reject(dwe, rp, wp, da);
      exp_i = exp_i_hold;
      exp_d = exp_d_hold;
      lat_i = 0; lat_d = 0; n_rd = 0; n_wr = 0;
      if (wi && wd) begin
`ifdef MEM_ARB_DPRIO_EN
         d_first = 1'b1;
`else
         d_first = last_i;
`endif
      end else begin
         d_first = wd;
      end
      for (int k = 0; k < 2; k++) begin
         take_d = (k == 0) ? d_first : !d_first;
         if (take_d && wd) begin
            lat_d = (lat_i != 0) ? 5 : 2;
            if (rej) exp_d = '0;
            else if (dwe) begin ref_store(da, wp, wdat); exp_d = '0; n_wr++; end
            else begin exp_d = ref_load(da, rp); n_rd++; end
            last_i = 1'b0;
         end else if (!take_d && wi) begin
            lat_i = (lat_d != 0) ? 5 : 2;
            exp_i = ref_load({ia[7:2], 2'b00}, 3'd0);
            n_rd++;
            last_i = 1'b1;
         end
      end

      rd0 = rd_cnt; wr0 = wr_cnt;
      i_req = wi; i_addr = ia;
      d_req = wd; d_we = dwe; d_read_part = rp; d_write_part = wp; d_addr = da; d_wdata = wdat;
      pend_i = wi; pend_d = wd;
      for (int cyc = 1; cyc <= 8 && (pend_i || pend_d); cyc++) begin
         @(negedge clk);
         if (i_ack) begin
            if (pend_i) begin
               check("i_ack_cycle", cyc, lat_i);
               check("i_rdata", i_rdata, exp_i);
               pend_i = 1'b0; i_req = 1'b0;
            end else check("i_ack_unexpected", i_ack, 1'b0);
         end
         if (d_ack) begin
            if (pend_d) begin
               check("d_ack_cycle", cyc, lat_d);
               check("d_rdata", d_rdata, exp_d);
               check("d_err", d_err, rej);
               pend_d = 1'b0; d_req = 1'b0;
            end else check("d_ack_unexpected", d_ack, 1'b0);
         end
      end
      if (pend_i) check("i_ack_timeout", 0, 1);
      if (pend_d) check("d_ack_timeout", 0, 1);
      i_req = 1'b0; d_req = 1'b0;
      check("mem_read_count", rd_cnt - rd0, n_rd);
      check("mem_write_count", wr_cnt - wr0, n_wr);
      check("i_rdata_hold", i_rdata, exp_i);
      check("d_rdata_hold", d_rdata, exp_d);
      exp_i_hold = exp_i;
      exp_d_hold = exp_d;
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_i_ack"},     i_ack, 1'b0);
      check({tag, "_d_ack"},     d_ack, 1'b0);
      check({tag, "_d_err"},     d_err, 1'b0);
      check({tag, "_i_rdata"},   i_rdata, 32'h0);
      check({tag, "_d_rdata"},   d_rdata, 32'h0);
      check({tag, "_mem_read"},  mem_read, 1'b0);
      check({tag, "_mem_write"}, mem_write, 1'b0);
      check({tag, "_mem_addr"},  mem_addr, 8'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int wr0;
      bit wi, wd, dwe;
      logic [7:0] da, ia;

      rst = 1'b1; pre_en = 1'b0; pre_a = '0; pre_d = '0;
      i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_read_part = 0; d_write_part = 0;
      d_addr = 0; d_wdata = 0;

      // Preload memory while in reset; word 1 (bytes 4..7) holds 9.
      for (int a = 0; a < 256; a++) begin
         @(negedge clk);
         pre_en = 1'b1;
         pre_a  = 8'(a);
         pre_d  = (a == 4) ? 8'h09 : (a >= 5 && a <= 7) ? 8'h00 : 8'($urandom);
         ref_mem[a] = pre_d;
      end
      @(negedge clk);
      pre_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1 check_quiet("reset");

      // Ties right after reset: D first, then I; repeated ties keep alternating.
      do_round(1, 1, 8'h04, 1'b0, RP_W, WP_W, 8'h10, 32'h0);
      for (int r = 0; r < 3; r++) begin
         gap(1);
         do_round(1, 1, 8'($urandom), 1'b0, RP_BU, WP_W, 8'($urandom), 32'h0);
      end

      // Lone fetch of word 1.
      gap(1);
      do_round(1, 0, 8'h04, 1'b0, RP_W, WP_W, 8'h00, 32'h0);
      check("fetch_word1", i_rdata, 32'd9);

      // Byte store then unsigned byte load from the same address.
      gap(1);
      do_round(0, 1, 8'h00, 1'b1, RP_W, WP_B, 8'h09, 32'h000000AB);
      gap(1);
      do_round(0, 1, 8'h00, 1'b0, RP_BU, WP_W, 8'h09, 32'h0);
      check("store_load_byte", d_rdata, 32'h000000AB);

      // Rejections: misaligned halfword load, illegal write part.
      gap(1);
      do_round(0, 1, 8'h00, 1'b0, RP_HS, WP_W, 8'h03, 32'h0);
      gap(1);
      do_round(0, 1, 8'h00, 1'b1, RP_W, 2'd3, 8'h20, 32'hDEADBEEF);

      // Randomized rounds.
      for (int r = 0; r < 80; r++) begin
         gap(1 + $urandom_range(0, 2));
         wi  = $urandom_range(0, 1);
         wd  = $urandom_range(0, 1);
         if (!wi && !wd) wd = 1'b1;
         dwe = $urandom_range(0, 1);
         da  = 8'($urandom);
         if ($urandom_range(0, 1) == 1) da = {da[7:2], 2'b00};
         ia  = 8'($urandom);
         do_round(wi, wd, ia, dwe, 3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
                  da, $urandom);
      end

      // Reset during ACCESS of a store: no write, no ack, quiet outputs.
      gap(1);
      wr0 = wr_cnt;
      d_req = 1'b1; d_we = 1'b1; d_write_part = WP_W; d_addr = 8'h40; d_wdata = 32'hCAFEF00D;
      @(negedge clk);
      rst = 1'b1;
      #1 check("reset_mid_mem_write", mem_write, 1'b0);
      @(negedge clk);
      rst = 1'b0; d_req = 1'b0;
      #1 check_quiet("post_reset");
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("post_reset_no_ack", d_ack, 1'b0);
      end
      check("post_reset_no_write", wr_cnt - wr0, 0);
      last_i = 1'b1; exp_i_hold = '0; exp_d_hold = '0;
      do_round(1, 1, 8'h04, 1'b0, RP_W, WP_W, 8'h40, 32'h0);

`ifdef MEM_ARB_DPRIO_EN
      begin
         bit seen;
         gap(1);
         i_req = 1'b1; i_addr = 8'h10;
         d_req = 1'b1; d_we = 1'b0; d_read_part = RP_W; d_addr = 8'h00;
         seen = 1'b0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (i_ack) seen = 1'b1;
         end
         check("dprio_i_starved", seen, 1'b0);
         seen = 1'b0;
         for (int c = 0; c < 4 && !seen; c++) begin
            @(negedge clk);
            if (d_ack) seen = 1'b1;
         end
         check("dprio_d_ack_seen", seen, 1'b1);
         d_req = 1'b0;
         seen = 1'b0;
         for (int c = 0; c < 3 && !seen; c++) begin
            @(negedge clk);
            if (i_ack) seen = 1'b1;
         end
         check("dprio_i_ack_after_drop", seen, 1'b1);
         check("dprio_i_rdata", i_rdata, ref_load(8'h10, 3'd0));
         i_req = 1'b0;
      end
`endif

      gap(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
